// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing constants and types for the physical register free list.
// Tags 0..ARCH_REG_NUM-1 are the reset architectural mappings; the rest start free.
package phys_reg_free_list_pkg;

  localparam int PHY_REG_NUM  = 64;
  localparam int ARCH_REG_NUM = 32;
  localparam int PHY_REG_SEL  = $clog2(PHY_REG_NUM);
  localparam int REG_SEL      = $clog2(ARCH_REG_NUM);
  localparam int FL_NUM       = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int FL_SEL       = $clog2(FL_NUM);

  // Pointer carries one extra wrap bit above the index
  typedef logic [FL_SEL:0]        fl_ptr_t;
  typedef logic [FL_SEL-1:0]      fl_idx_t;
  typedef logic [PHY_REG_SEL-1:0] phy_tag_t;
  typedef logic [1:0]             fl_inc_t;

endpackage

// File: rtl/phys_reg_free_list_ptr_adv.sv
// Advances a wrap-bit free-list pointer by 0, 1 or 2 entries.
// FL_NUM is a power of two, so plain modular addition toggles the wrap bit.
module fl_ptr_adv
  import phys_reg_free_list_pkg::*;
(
  input  fl_ptr_t ptr,
  input  fl_inc_t inc,
  output fl_ptr_t ptr_next
);

  assign ptr_next = ptr + fl_ptr_t'(inc);

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: up to two allocations and two
// commit releases per cycle, with a commit-side head used to recover on flush.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_req_1,
  input  logic                   alloc_req_2,
  input  logic                   stall_RN,
  output logic [PHY_REG_SEL-1:0] alloc_tag_1,
  output logic [PHY_REG_SEL-1:0] alloc_tag_2,
  output logic                   alloc_ok,
  output logic [FL_SEL:0]        free_count,
  input  logic                   commit_valid_1,
  input  logic                   commit_valid_2,
  input  logic [REG_SEL-1:0]     commit_dst_1,
  input  logic [REG_SEL-1:0]     commit_dst_2,
  input  logic [PHY_REG_SEL-1:0] commit_release_tag_1,
  input  logic [PHY_REG_SEL-1:0] commit_release_tag_2,
  input  logic                   flush
);

  localparam fl_idx_t IDX_ONE = fl_idx_t'(1);

  phy_tag_t fl_mem [FL_NUM];

  fl_ptr_t head_reg, tail_reg, chead_reg;
  fl_ptr_t head_next, tail_next, chead_next;
  fl_ptr_t head_adv;

  fl_idx_t head_idx, head_idx_p1, tail_idx, tail_idx_p1;

  logic     rel_1, rel_2;
  logic     wr0_en, wr1_en;
  phy_tag_t wr0_tag;
  fl_inc_t  nreq, nrel, head_inc;
  logic     alloc_fire;

  // x0 never owns a physical tag, so its commit frees nothing
  assign rel_1 = commit_valid_1 && (commit_dst_1 != '0);
  assign rel_2 = commit_valid_2 && (commit_dst_2 != '0);
  assign nrel  = fl_inc_t'(rel_1) + fl_inc_t'(rel_2);
  assign nreq  = fl_inc_t'(alloc_req_1) + fl_inc_t'(alloc_req_2);

  assign free_count = tail_reg - head_reg;
  assign alloc_ok   = (free_count >= fl_ptr_t'(nreq));
  assign alloc_fire = alloc_ok && !stall_RN && !flush;
  assign head_inc   = alloc_fire ? nreq : 2'd0;

  assign head_idx    = head_reg[FL_SEL-1:0];
  assign head_idx_p1 = head_idx + IDX_ONE;
  assign tail_idx    = tail_reg[FL_SEL-1:0];
  assign tail_idx_p1 = tail_idx + IDX_ONE;

  // Slot 2 takes the head entry when slot 1 did not ask for one
  assign alloc_tag_1 = fl_mem[head_idx];
  assign alloc_tag_2 = alloc_req_1 ? fl_mem[head_idx_p1] : fl_mem[head_idx];

  // Releases are compacted: the first valid one always lands at tail
  assign wr0_en  = rel_1 || rel_2;
  assign wr1_en  = rel_1 && rel_2;
  assign wr0_tag = rel_1 ? commit_release_tag_1 : commit_release_tag_2;

  fl_ptr_adv u_head_adv (
    .ptr      (head_reg),
    .inc      (head_inc),
    .ptr_next (head_adv)
  );

  fl_ptr_adv u_tail_adv (
    .ptr      (tail_reg),
    .inc      (nrel),
    .ptr_next (tail_next)
  );

  fl_ptr_adv u_chead_adv (
    .ptr      (chead_reg),
    .inc      (nrel),
    .ptr_next (chead_next)
  );

  // On flush, everything past the committed point becomes free again
  assign head_next = flush ? chead_next : head_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      chead_reg <= '0;
      tail_reg  <= fl_ptr_t'(FL_NUM);
    end else begin
      head_reg  <= head_next;
      chead_reg <= chead_next;
      tail_reg  <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_NUM; i++) begin
        fl_mem[i] <= phy_tag_t'(ARCH_REG_NUM + i);
      end
    end else begin
      if (wr0_en) begin
        fl_mem[tail_idx] <= wr0_tag;
      end
      if (wr1_en) begin
        fl_mem[tail_idx_p1] <= commit_release_tag_2;
      end
    end
  end

  // Pointer ordering chead <= head <= tail, all within one list length
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_free_bound: assert (free_count <= fl_ptr_t'(FL_NUM));
      a_chead_bound: assert (fl_ptr_t'(head_reg - chead_reg) <= fl_ptr_t'(FL_NUM));
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue/ROB/rename-map reference model
// predicts every cycle's outputs; a negedge monitor compares them to the DUT.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   alloc_req_1, alloc_req_2, stall_RN, flush;
  logic [PHY_REG_SEL-1:0] alloc_tag_1, alloc_tag_2;
  logic                   alloc_ok;
  logic [FL_SEL:0]        free_count;
  logic                   commit_valid_1, commit_valid_2;
  logic [REG_SEL-1:0]     commit_dst_1, commit_dst_2;
  logic [PHY_REG_SEL-1:0] commit_release_tag_1, commit_release_tag_2;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_req_1          (alloc_req_1),
    .alloc_req_2          (alloc_req_2),
    .stall_RN             (stall_RN),
    .alloc_tag_1          (alloc_tag_1),
    .alloc_tag_2          (alloc_tag_2),
    .alloc_ok             (alloc_ok),
    .free_count           (free_count),
    .commit_valid_1       (commit_valid_1),
    .commit_valid_2       (commit_valid_2),
    .commit_dst_1         (commit_dst_1),
    .commit_dst_2         (commit_dst_2),
    .commit_release_tag_1 (commit_release_tag_1),
    .commit_release_tag_2 (commit_release_tag_2),
    .flush                (flush)
  );

  typedef struct {
    int dst;
    int new_tag;
    int old_tag;
  } rob_t;

  typedef struct {
    bit req1;
    bit req2;
    bit chk_t1;
    bit chk_t2;
    bit drain;
    int t1;
    int t2;
    int ok;
    int cnt;
  } exp_t;

  int   free_q[$];
  rob_t rob[$];
  exp_t exp_q[$];
  int   arch_map[ARCH_REG_NUM];
  int   spec_map[ARCH_REG_NUM];
  int   seen[PHY_REG_NUM];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", name, act, expv, txn);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    rob.delete();
    for (int i = 0; i < FL_NUM; i++) free_q.push_back(ARCH_REG_NUM + i);
    for (int i = 0; i < ARCH_REG_NUM; i++) begin
      arch_map[i] = i;
      spec_map[i] = i;
    end
  endtask

  task automatic alloc_one();
    rob_t r;
    r.new_tag = free_q.pop_front();
    r.dst     = int'($urandom_range(1, ARCH_REG_NUM - 1));
    r.old_tag = spec_map[r.dst];
    spec_map[r.dst] = r.new_tag;
    rob.push_back(r);
  endtask

  // Commit kind: 0 none, 1 x0 instruction, 2 oldest ROB entry
  task automatic drive_commit(input int kind, output logic v, output logic [REG_SEL-1:0] d,
                              output logic [PHY_REG_SEL-1:0] t, inout int rel[$]);
    rob_t c;
    v = 1'b0;
    d = '0;
    t = PHY_REG_SEL'($urandom_range(0, PHY_REG_NUM - 1));
    if (kind == 1) begin
      v = 1'b1;
    end else if (kind == 2 && rob.size() > 0) begin
      c = rob.pop_front();
      v = 1'b1;
      d = REG_SEL'(c.dst);
      t = PHY_REG_SEL'(c.old_tag);
      arch_map[c.dst] = c.new_tag;
      rel.push_back(c.old_tag);
    end
  endtask

  // One cycle: drive inputs, predict outputs, update model, advance past the edge
  task automatic step(input bit r1, input bit r2, input bit st, input int k1, input int k2,
                      input bit fl, input bit drain);
    exp_t e;
    int   rel[$];
    int   nreq;
    logic v;
    logic [REG_SEL-1:0] d;
    logic [PHY_REG_SEL-1:0] t;

    drive_commit(k1, v, d, t, rel);
    commit_valid_1 = v; commit_dst_1 = d; commit_release_tag_1 = t;
    drive_commit(k2, v, d, t, rel);
    commit_valid_2 = v; commit_dst_2 = d; commit_release_tag_2 = t;
    alloc_req_1 = r1;
    alloc_req_2 = r2;
    stall_RN    = st;
    flush       = fl;

    nreq     = int'(r1) + int'(r2);
    e.req1   = r1;
    e.req2   = r2;
    e.cnt    = free_q.size();
    e.ok     = (free_q.size() >= nreq) ? 1 : 0;
    e.chk_t1 = free_q.size() >= 1;
    e.t1     = e.chk_t1 ? free_q[0] : 0;
    if (r1) begin
      e.chk_t2 = free_q.size() >= 2;
      e.t2     = e.chk_t2 ? free_q[1] : 0;
    end else begin
      e.chk_t2 = free_q.size() >= 1;
      e.t2     = e.chk_t2 ? free_q[0] : 0;
    end
    e.drain = drain && (e.ok == 1) && !st && !fl;
    exp_q.push_back(e);

    if (e.ok == 1 && !st && !fl) begin
      if (r1) alloc_one();
      if (r2) alloc_one();
    end
    if (fl) begin
      for (int i = rob.size() - 1; i >= 0; i--) free_q.push_front(rob[i].new_tag);
      rob.delete();
      spec_map = arch_map;
    end
    foreach (rel[i]) free_q.push_back(rel[i]);

    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      check("alloc_ok", int'(alloc_ok), e.ok);
      check("free_count", int'(free_count), e.cnt);
      if (e.chk_t1) check("alloc_tag_1", int'(alloc_tag_1), e.t1);
      if (e.chk_t2) check("alloc_tag_2", int'(alloc_tag_2), e.t2);
      if (e.drain) begin
        if (e.req1) seen[alloc_tag_1]++;
        if (e.req2) seen[alloc_tag_2]++;
      end
      $display("txn %0d: req=%0b%0b ok=%0b cnt=%0d tag1=%0d tag2=%0d", txn, e.req1, e.req2,
               alloc_ok, free_count, alloc_tag_1, alloc_tag_2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    alloc_req_1 = 0; alloc_req_2 = 0; stall_RN = 0; flush = 0;
    commit_valid_1 = 0; commit_valid_2 = 0;
    commit_dst_1 = '0; commit_dst_2 = '0;
    commit_release_tag_1 = '0; commit_release_tag_2 = '0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    idle_inputs();
    foreach (seen[i]) seen[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Drain the list two at a time, then probe the empty boundary
    repeat (16) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Real commit plus x0 commit: only one tag returns
    step(0, 0, 0, 2, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2, 2, 0, 0);
    // Allocate, commit some, flush alongside a commit and an ignored request
    repeat (3) step(1, 1, 0, 2, 2, 0, 0);
    step(0, 0, 0, 2, 2, 0, 0);
    step(1, 1, 0, 2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           ($urandom_range(0, 5) >= 3) ? 2 : int'($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) >= 3) ? 2 : int'($urandom_range(0, 5) == 0),
           $urandom_range(0, 63) == 0, 0);
    end

    // Recover everything, then account for every physical tag exactly once
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (FL_NUM / 2) step(1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < PHY_REG_NUM; t++) begin
      cnt = seen[t];
      for (int a = 0; a < ARCH_REG_NUM; a++) if (arch_map[a] == t) cnt++;
      check("tag_held_once", cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
